// File: rtl/gctr_pkg.sv
// ============================================================================
// Module  : gctr_pkg
// Brief   : Shared types and helpers for the GCTR streaming engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gctr_pkg;

    localparam int c_max_w = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int bw_f(input int dw);
        return $clog2(dw / 8) + 1;
    endfunction

    // Increment only the low s bits; everything above is carried through untouched.
    function automatic logic [c_max_w-1:0] inc_s(input logic [c_max_w-1:0] cb, input int s);
        logic [c_max_w-1:0] m;
        m = (s >= c_max_w) ? {c_max_w{1'b1}} : ((c_max_w'(1) << s) - c_max_w'(1));
        return (cb & ~m) | ((cb + c_max_w'(1)) & m);
    endfunction

    // Mask keeping the first nb bytes (MSB-first) of a dw-bit word.
    function automatic logic [c_max_w-1:0] byte_mask(input int nb, input int dw);
        logic [c_max_w-1:0] m;
        m = ~({c_max_w{1'b1}} >> (8 * nb));
        return m >> (c_max_w - dw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gctr_stream_if.sv
// ============================================================================
// Module  : gctr_stream_if
// Brief   : Data-in, cipher request/response and data-out handshakes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface gctr_stream_if
    import gctr_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ICB_WIDTH  = 128
);
    localparam int BW = bw_f(DATA_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic [BW-1:0]         in_bytes;

    logic                  ciph_req_valid;
    logic                  ciph_req_ready;
    logic [ICB_WIDTH-1:0]  ciph_req_block;
    logic                  ciph_rsp_valid;
    logic                  ciph_rsp_ready;
    logic [DATA_WIDTH-1:0] ciph_rsp_block;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic [BW-1:0]         out_bytes;

    modport master (
        input  in_valid, in_data, in_last, in_bytes,
        input  ciph_req_ready, ciph_rsp_valid, ciph_rsp_block,
        input  out_ready,
        output in_ready,
        output ciph_req_valid, ciph_req_block, ciph_rsp_ready,
        output out_valid, out_data, out_last, out_bytes
    );

    modport slave (
        output in_valid, in_data, in_last, in_bytes,
        output ciph_req_ready, ciph_rsp_valid, ciph_rsp_block,
        output out_ready,
        input  in_ready,
        input  ciph_req_valid, ciph_req_block, ciph_rsp_ready,
        input  out_valid, out_data, out_last, out_bytes
    );

endinterface

`default_nettype wire

// File: rtl/gctr_fifo.sv
// ============================================================================
// Module  : gctr_fifo
// Brief   : Synchronous FIFO with full/empty flags and same-cycle push/pop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gctr_fifo #(
    parameter int WIDTH = 134,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_pop_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr;
    logic [c_aw:0]    r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_full     = (r_wr[c_aw] != r_rd[c_aw]) && (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]);
    assign o_empty    = (r_wr == r_rd);
    assign o_pop_data = r_mem[r_rd[c_aw-1:0]];
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[c_aw-1:0]] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/gctr_stream.sv
// ============================================================================
// Module  : gctr_stream
// Brief   : Streaming GCM counter-mode engine with outstanding cipher requests.
//           Define GCTR_PARTIAL_MASK_EN to zero unused bytes of the final block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gctr_stream
    import gctr_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ICB_WIDTH  = 128,
    parameter int S          = 32,
    parameter int DEPTH      = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 start,
    input  wire logic [ICB_WIDTH-1:0] icb,
    output logic                      busy,
    output logic                      done,
    output logic      [ICB_WIDTH-1:0] cb_next,
    output logic      [31:0]          blk_count,
    gctr_stream_if.master             bus
);
    localparam int BW      = bw_f(DATA_WIDTH);
    localparam int c_nbytes = DATA_WIDTH / 8;
    localparam int c_fw     = DATA_WIDTH + 1 + BW;
    localparam logic [BW-1:0] c_full_bytes = BW'(c_nbytes);

    state_t                r_state;
    logic                  r_busy;
    logic [ICB_WIDTH-1:0]  r_cb;
    logic [31:0]           r_blk_count;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic [BW-1:0]         r_out_bytes;

    logic                  w_run;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_rsp_fire;
    logic                  w_out_fire;
    logic [BW-1:0]         w_push_bytes;
    logic [c_fw-1:0]       w_push_word;
    logic [c_fw-1:0]       w_head;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_last;
    logic [BW-1:0]         w_head_bytes;
    logic [DATA_WIDTH-1:0] w_xor;
    logic [DATA_WIDTH-1:0] w_result;
    logic [ICB_WIDTH-1:0]  w_cb_inc;

    assign w_run = (r_state == ST_RUN);

    // Input and cipher request are one joint event, gated by FIFO space.
    assign bus.ciph_req_valid = w_run & bus.in_valid & ~w_full;
    assign bus.in_ready       = w_run & bus.ciph_req_ready & ~w_full;
    assign bus.ciph_req_block = r_cb;
    assign w_accept           = bus.in_valid & bus.in_ready;

    assign w_push_bytes = (bus.in_last && (bus.in_bytes != '0)) ? bus.in_bytes : c_full_bytes;
    assign w_push_word  = {bus.in_data, bus.in_last, w_push_bytes};

    gctr_fifo #(
        .WIDTH (c_fw),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_push_data (w_push_word),
        .i_pop       (w_rsp_fire),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign w_head_data  = w_head[c_fw-1 -: DATA_WIDTH];
    assign w_head_last  = w_head[BW];
    assign w_head_bytes = w_head[BW-1:0];

    assign bus.ciph_rsp_ready = ~w_empty & (~r_out_valid | bus.out_ready);
    assign w_rsp_fire         = bus.ciph_rsp_valid & bus.ciph_rsp_ready;
    assign w_out_fire         = r_out_valid & bus.out_ready;

    assign w_xor = w_head_data ^ bus.ciph_rsp_block;

`ifdef GCTR_PARTIAL_MASK_EN
    logic [DATA_WIDTH-1:0] w_mask;
    assign w_mask   = w_head_last ? DATA_WIDTH'(byte_mask(int'(w_head_bytes), DATA_WIDTH))
                                  : {DATA_WIDTH{1'b1}};
    assign w_result = w_xor & w_mask;
`else
    assign w_result = w_xor;
`endif

    assign w_cb_inc = ICB_WIDTH'(inc_s(c_max_w'(r_cb), S));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_cb        <= '0;
            r_blk_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_cb        <= icb;
                        r_blk_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_cb <= w_cb_inc;
                        if (r_blk_count != '1) r_blk_count <= r_blk_count + 32'd1;
                        if (bus.in_last) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_fire && r_out_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_bytes <= '0;
        end else if (w_rsp_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_last  <= w_head_last;
            r_out_bytes <= w_head_bytes;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_bytes = r_out_bytes;

    assign busy      = r_busy;
    assign done      = w_out_fire & r_out_last & (r_state == ST_DRAIN);
    assign cb_next   = r_cb;
    assign blk_count = r_blk_count;

endmodule

`default_nettype wire
